// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - writeback arbiter: ALU/MEM round-robin into a FIFO feeding the register-bank write port
module wb_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_addr_d,
  output logic [DATA_W-1:0]        rf_data,
  input  logic [ADDR_W-1:0]        fwd_addr_a,
  input  logic [ADDR_W-1:0]        fwd_addr_b,
  output logic                     fwd_hit_a,
  output logic [DATA_W-1:0]        fwd_data_a,
  output logic                     fwd_hit_b,
  output logic [DATA_W-1:0]        fwd_data_b,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage; validity comes only from count/rd_ptr, so contents need no reset
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              rr_q, rr_d;          // 0: ALU wins next tie, 1: MEM wins next tie
  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_nq;
  logic [DATA_W-1:0] rf_data_q, rf_data_nq;

  logic              full, alu_gnt, mem_gnt, enq, deq;
  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_data;
  logic [PW-1:0]     slot;

  // Arbitration, enqueue/dequeue decisions and next-state computation
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    alu_gnt  = alu_valid && !full && (!mem_valid || !rr_q);
    mem_gnt  = mem_valid && !full && (!alu_valid || rr_q);
    enq_addr = alu_gnt ? alu_addr : mem_addr;
    enq_data = alu_gnt ? alu_data : mem_data;
    // Writes to register zero complete the handshake but are dropped here
    enq      = (alu_gnt || mem_gnt) && (enq_addr != '0);
    deq      = (count_q != '0);

    rr_d = rr_q;
    if (alu_valid && mem_valid && !full) begin
      rr_d = alu_gnt;
    end

    wr_ptr_d = wr_ptr_q + PW'(enq);
    rd_ptr_d = rd_ptr_q + PW'(deq);
    count_d  = count_q + CW'(enq) - CW'(deq);

    rf_write_d = deq;
    rf_addr_nq = deq ? addr_mem_q[rd_ptr_q] : rf_addr_q;
    rf_data_nq = deq ? data_mem_q[rd_ptr_q] : rf_data_q;
  end

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;
  assign rf_write  = rf_write_q;
  assign rf_addr_d = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign count     = count_q;

  // Control state and bank-facing output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_q       <= 1'b0;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_nq;
      rf_data_q  <= rf_data_nq;
    end
  end

  // FIFO entry write on enqueue
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem_q[wr_ptr_q] <= enq_addr;
      data_mem_q[wr_ptr_q] <= enq_data;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match overrides; rf_* entry is oldest
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    slot       = '0;
    if (rf_write_q && (fwd_addr_a != '0) && (rf_addr_q == fwd_addr_a)) begin
      fwd_hit_a  = 1'b1;
      fwd_data_a = rf_data_q;
    end
    if (rf_write_q && (fwd_addr_b != '0) && (rf_addr_q == fwd_addr_b)) begin
      fwd_hit_b  = 1'b1;
      fwd_data_b = rf_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((fwd_addr_a != '0) && (addr_mem_q[slot] == fwd_addr_a)) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = data_mem_q[slot];
        end
        if ((fwd_addr_b != '0) && (addr_mem_q[slot] == fwd_addr_b)) begin
          fwd_hit_b  = 1'b1;
          fwd_data_b = data_mem_q[slot];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - table-driven bench with rf write scoreboard for wb_write_arbiter
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0]  alu_addr = '0, mem_addr = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, rf_write, fwd_hit_a, fwd_hit_b;
  logic [4:0]  rf_addr_d;
  logic [31:0] rf_data, fwd_data_a, fwd_data_b;
  logic [4:0]  fwd_addr_a = '0, fwd_addr_b = '0;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic [4:0]  fa;
    logic [4:0]  fb;
    logic        ear;
    logic        emr;
    logic [2:0]  ecnt;
    logic        eha;
    logic [31:0] eda;
    logic        ehb;
    logic [31:0] edb;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];

  wb_write_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_write(rf_write), .rf_addr_d(rf_addr_d), .rf_data(rf_data),
    .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
    .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
    .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] da(input int a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  function automatic logic [31:0] dm(input int a);
    return 32'hB000_0000 + 32'(a);
  endfunction

  function automatic vec_t mk(input int av, input int aa, input logic [31:0] ad,
                              input int mv, input int ma, input logic [31:0] md,
                              input int fa, input int fb, input int ear, input int emr,
                              input int ecnt, input int eha, input logic [31:0] eda,
                              input int ehb, input logic [31:0] edb);
    vec_t v;
    v.av = 1'(av);   v.aa = 5'(aa);  v.ad = ad;
    v.mv = 1'(mv);   v.ma = 5'(ma);  v.md = md;
    v.fa = 5'(fa);   v.fb = 5'(fb);
    v.ear = 1'(ear); v.emr = 1'(emr); v.ecnt = 3'(ecnt);
    v.eha = 1'(eha); v.eda = eda; v.ehb = 1'(ehb); v.edb = edb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, then check the rf strobe after the edge
  task automatic apply(input vec_t v);
    wr_t w;
    @(negedge clk);
    alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
    mem_valid = v.mv; mem_addr = v.ma; mem_data = v.md;
    fwd_addr_a = v.fa; fwd_addr_b = v.fb;
    #1;
    chk("alu_ready", 32'(alu_ready), 32'(v.ear));
    chk("mem_ready", 32'(mem_ready), 32'(v.emr));
    chk("count", 32'(count), 32'(v.ecnt));
    chk("fwd_hit_a", 32'(fwd_hit_a), 32'(v.eha));
    chk("fwd_data_a", fwd_data_a, v.eda);
    chk("fwd_hit_b", 32'(fwd_hit_b), 32'(v.ehb));
    chk("fwd_data_b", fwd_data_b, v.edb);
    if (v.ear && v.aa != 5'd0) begin w.addr = v.aa; w.data = v.ad; sb.push_back(w); end
    if (v.emr && v.ma != 5'd0) begin w.addr = v.ma; w.data = v.md; sb.push_back(w); end
    @(posedge clk);
    #1;
    chk("rf_write", 32'(rf_write), 32'(v.ecnt != 3'd0));
    if (rf_write) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rf_unexpected: got write addr %0d data %0h, want no pending entry", rf_addr_d, rf_data);
      end else begin
        w = sb.pop_front();
        chk("rf_addr_d", 32'(rf_addr_d), 32'(w.addr));
        chk("rf_data", rf_data, w.data);
      end
    end
  endtask

  task automatic idle(input int ecnt);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ecnt, 0, 0, 0, 0));
  endtask

  initial begin
    #3;
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_rf_addr", 32'(rf_addr_d), 32'd0);
    chk("rst_rf_data", rf_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // single ALU write, handshake tie alternation, forwarding from FIFO and rf stage
    vecs.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 1, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, da(1), 1, 2, dm(2), 1, 2, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4, da(4), 1, 2, dm(2), 1, 2, 0, 1, 1, 1, da(1), 0, 0));
    vecs.push_back(mk(1, 4, da(4), 1, 5, dm(5), 2, 1, 1, 0, 1, 1, dm(2), 1, da(1)));
    vecs.push_back(mk(1, 6, da(6), 1, 5, dm(5), 4, 2, 0, 1, 1, 1, da(4), 1, dm(2)));
    vecs.push_back(mk(1, 6, da(6), 1, 7, dm(7), 5, 1, 1, 0, 1, 1, dm(5), 0, 0));
    vecs.push_back(mk(1, 8, da(8), 1, 7, dm(7), 6, 5, 0, 1, 1, 1, da(6), 1, dm(5)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 7, 6, 0, 0, 1, 1, dm(7), 1, da(6)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 1, dm(7), 0, 0));
    foreach (vecs[i]) apply(vecs[i]);

    // streaming run of 10 ALU entries wraps the pointers; fwd_b tracks the pending entry
    for (int i = 0; i < 10; i++) begin
      apply(mk(1, 8 + i, 32'hC000_0000 + 32'(i), 0, 0, 0, 0, (i == 0) ? 0 : 7 + i,
               1, 0, (i == 0) ? 0 : 1, 0, 0, (i == 0) ? 0 : 1,
               (i == 0) ? 32'd0 : 32'hC000_0000 + 32'(i - 1)));
    end
    idle(1);
    idle(0);

    // register-zero drops, tie after a dropped grant, same-register pending forwarding
    vecs.delete();
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h55, 1, 9, dm(9), 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 12, da(12), 1, 9, dm(9), 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 12, da(12), 0, 0, 0, 9, 0, 1, 0, 1, 1, dm(9), 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9, 12, 0, 0, 1, 1, dm(9), 1, da(12)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 12, 9, 0, 0, 0, 1, da(12), 0, 0));
    vecs.push_back(mk(1, 7, 32'h11, 0, 0, 0, 7, 7, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 7, 32'h22, 0, 0, 0, 7, 7, 1, 0, 1, 1, 32'h11, 1, 32'h11));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 1, 1, 32'h22, 1, 32'h22));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 7, 0, 0, 0, 0, 0, 1, 32'h22));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 7, 0, 0, 0, 0, 0, 0, 0));
    foreach (vecs[i]) apply(vecs[i]);

    // asynchronous reset mid-drain, with the round-robin pointer favouring MEM beforehand
    apply(mk(1, 20, da(20), 1, 22, dm(22), 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 21, da(21), 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0; fwd_addr_a = 5'd20; fwd_addr_b = 5'd21;
    reset = 1'b1;
    #1;
    chk("arst_rf_write", 32'(rf_write), 32'd0);
    chk("arst_rf_addr", 32'(rf_addr_d), 32'd0);
    chk("arst_rf_data", rf_data, 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_fwd_hit_b", 32'(fwd_hit_b), 32'd0);
    chk("arst_fwd_hit_a", 32'(fwd_hit_a), 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(0);
    idle(0);
    idle(0);
    apply(mk(1, 23, da(23), 1, 24, dm(24), 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 1, 24, dm(24), 23, 0, 0, 1, 1, 1, da(23), 0, 0));
    idle(1);
    idle(0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
